// File: rtl/seven_seg_scroller.sv
// Multi-digit seven-segment display engine: a character buffer viewed through a
// sliding window of DIGITS characters, with optional timed scrolling and blinking.
// Segment outputs are active-low, bit order abcdefg (bit 6 = a).
module seven_seg_scroller #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned TICKS       = 12_500_000,
    parameter int unsigned BLINK_TICKS = 6_250_000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [5:0]               wr_data,
    input  logic [$clog2(DEPTH):0]   msg_len,
    input  logic [1:0]               mode,
    output logic [7*DIGITS-1:0]      segments,
    output logic [$clog2(DEPTH)-1:0] window_pos,
    output logic                     wrap
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned TW = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [5:0] CodeBlank = 6'd63;

    // Active-low glyph table; codes 36..63 are blank.
    function automatic logic [6:0] glyph(input logic [5:0] code);
        logic [6:0] g;
        case (code)
            6'd0:    g = 7'b000_0001;
            6'd1:    g = 7'b100_1111;
            6'd2:    g = 7'b001_0010;
            6'd3:    g = 7'b000_0110;
            6'd4:    g = 7'b100_1100;
            6'd5:    g = 7'b010_0100;
            6'd6:    g = 7'b010_0000;
            6'd7:    g = 7'b000_1111;
            6'd8:    g = 7'b000_0000;
            6'd9:    g = 7'b000_0100;
            6'd10:   g = 7'b000_1000; // A
            6'd11:   g = 7'b110_0000; // b
            6'd12:   g = 7'b011_0001; // C
            6'd13:   g = 7'b100_0010; // d
            6'd14:   g = 7'b011_0000; // E
            6'd15:   g = 7'b011_1000; // F
            6'd16:   g = 7'b010_0001; // G
            6'd17:   g = 7'b110_1000; // h
            6'd18:   g = 7'b111_1001; // I
            6'd19:   g = 7'b100_0011; // J
            6'd20:   g = 7'b101_0000; // K
            6'd21:   g = 7'b111_0001; // L
            6'd22:   g = 7'b010_1011; // M
            6'd23:   g = 7'b110_1010; // n
            6'd24:   g = 7'b110_0010; // o
            6'd25:   g = 7'b001_1000; // P
            6'd26:   g = 7'b000_1100; // q
            6'd27:   g = 7'b111_1010; // r
            6'd28:   g = 7'b010_0100; // S
            6'd29:   g = 7'b111_0000; // t
            6'd30:   g = 7'b100_0001; // U
            6'd31:   g = 7'b110_0011; // v
            6'd32:   g = 7'b101_0100; // W
            6'd33:   g = 7'b100_1000; // X
            6'd34:   g = 7'b100_0100; // y
            6'd35:   g = 7'b001_0010; // Z
            default: g = 7'b111_1111;
        endcase
        return g;
    endfunction

    logic [5:0]          buf_q [DEPTH];
    logic [1:0]          mode_q;
    logic [TW-1:0]       tick_q, tick_d;
    logic [BW-1:0]       blink_q, blink_d;
    logic                phase_q, phase_d;
    logic [AW-1:0]       window_pos_q, window_pos_d;
    logic                wrap_q, wrap_d;
    logic [7*DIGITS-1:0] segments_q, segments_d;

    logic [AW:0] len_eff;
    logic [AW:0] win_inc;
    logic [AW:0] idx, idx_inc;
    logic        mode_chg, win_oor, tick_tc, blink_tc, wr_ok;

    assign len_eff  = ((msg_len == '0) || (msg_len > (AW+1)'(DEPTH))) ? (AW+1)'(DEPTH) : msg_len;
    assign win_inc  = {1'b0, window_pos_q} + (AW+1)'(1);
    assign win_oor  = {1'b0, window_pos_q} >= len_eff;
    assign mode_chg = (mode != mode_q);
    assign tick_tc  = (tick_q == TW'(TICKS - 1));
    assign blink_tc = (blink_q == BW'(BLINK_TICKS - 1));
    assign wr_ok    = ({1'b0, wr_addr} < (AW+1)'(DEPTH));

    // Next-state for scroll position, tick/blink counters and the wrap pulse.
    always_comb begin
        tick_d       = tick_q;
        blink_d      = blink_q;
        phase_d      = phase_q;
        window_pos_d = window_pos_q;
        wrap_d       = 1'b0;
        if (mode_chg) begin
            // A new mode restarts the display from a known state.
            tick_d       = '0;
            blink_d      = '0;
            phase_d      = 1'b1;
            window_pos_d = '0;
        end else begin
            if (mode_q[0]) begin
                tick_d = tick_tc ? '0 : tick_q + TW'(1);
                if (win_oor) begin
                    // Message shrank under the window: snap back silently.
                    window_pos_d = '0;
                end else if (tick_tc) begin
                    if (win_inc == len_eff) begin
                        window_pos_d = '0;
                        wrap_d       = 1'b1;
                    end else begin
                        window_pos_d = win_inc[AW-1:0];
                    end
                end
            end else begin
                tick_d       = '0;
                window_pos_d = '0;
            end
            if (mode_q[1]) begin
                blink_d = blink_tc ? '0 : blink_q + BW'(1);
                if (blink_tc) begin
                    phase_d = ~phase_q;
                end
            end else begin
                blink_d = '0;
                phase_d = 1'b1;
            end
        end
    end

    // Decode the visible window, leftmost digit first, wrapping modulo len_eff.
    always_comb begin
        segments_d = '1;
        idx        = win_oor ? '0 : {1'b0, window_pos_q};
        idx_inc    = '0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            if (phase_q) begin
                segments_d[7*d +: 7] = glyph(buf_q[idx[AW-1:0]]);
            end
            idx_inc = idx + (AW+1)'(1);
            idx     = (idx_inc >= len_eff) ? '0 : idx_inc;
        end
    end

    // Message buffer; cleared to blank on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= CodeBlank;
            end
        end else if (wr_en && wr_ok) begin
            buf_q[wr_addr] <= wr_data;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q       <= 2'b00;
            tick_q       <= '0;
            blink_q      <= '0;
            phase_q      <= 1'b1;
            window_pos_q <= '0;
            wrap_q       <= 1'b0;
            segments_q   <= '1;
        end else begin
            mode_q       <= mode;
            tick_q       <= tick_d;
            blink_q      <= blink_d;
            phase_q      <= phase_d;
            window_pos_q <= window_pos_d;
            wrap_q       <= wrap_d;
            segments_q   <= segments_d;
        end
    end

    assign segments   = segments_q;
    assign window_pos = window_pos_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_seven_seg_scroller.sv
// Self-checking bench for seven_seg_scroller with DIGITS=4, DEPTH=8, TICKS=4, BLINK_TICKS=3.
// Expected values are queued as stimulus is driven and popped when the DUT is sampled.
module tb_seven_seg_scroller;

    localparam logic [27:0] All1 = 28'hFFF_FFFF;
    localparam logic [6:0]  G0   = 7'b000_0001;
    localparam logic [6:0]  G1   = 7'b100_1111;
    localparam logic [6:0]  G8   = 7'b000_0000;
    localparam logic [6:0]  GA   = 7'b000_1000;
    localparam logic [6:0]  GH   = 7'b110_1000;

    typedef struct {
        logic [27:0] seg;
        logic [27:0] msk;
        int          pos;  // -1: don't care
        int          wrp;  // -1: don't care
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [5:0]  wr_data;
    logic [3:0]  msg_len;
    logic [1:0]  mode;
    logic [27:0] segments;
    logic [2:0]  window_pos;
    logic        wrap;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    seven_seg_scroller #(
        .DIGITS     (4),
        .DEPTH      (8),
        .TICKS      (4),
        .BLINK_TICKS(3)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .msg_len   (msg_len),
        .mode      (mode),
        .segments  (segments),
        .window_pos(window_pos),
        .wrap      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(logic [27:0] s, logic [27:0] m, int p, int w);
        exp_t e;
        e.seg = s;
        e.msk = m;
        e.pos = p;
        e.wrp = w;
        return e;
    endfunction

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [5:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        cyc(1);
        wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        #1 reset_n = 1'b0;
        #1;
        sb.push_back(mk(All1, All1, 0, 0));
        e = sb.pop_front();
        n_vec++;
        if ((segments !== e.seg) || (window_pos !== 3'(e.pos)) || (wrap !== 1'(e.wrp))) begin
            n_err++;
            $display("FAIL reset_hold: seg=%h pos=%0d wrap=%b, required seg=%h pos=%0d wrap=%0d",
                     segments, window_pos, wrap, e.seg, e.pos, e.wrp);
        end
        cyc(2);
        reset_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            sb.push_back(mk(All1, All1, 0, 0));
            cyc(1);
            e = sb.pop_front();
            n_vec++;
            if ((segments !== e.seg) || (window_pos !== 3'(e.pos)) || (wrap !== 1'(e.wrp))) begin
                n_err++;
                $display("FAIL reset_release k=%0d: seg=%h pos=%0d wrap=%b, required seg=%h pos=%0d wrap=%0d",
                         k, segments, window_pos, wrap, e.seg, e.pos, e.wrp);
            end
        end
    endtask

    task automatic test_static();
        exp_t e;
        msg_len = 4'd4;
        mode    = 2'b00;
        wr(3'd0, 6'd1);
        wr(3'd1, 6'd0);
        wr(3'd2, 6'd8);
        wr(3'd3, 6'd10);
        for (int k = 1; k <= 3; k++) begin
            sb.push_back(mk({G1, G0, G8, GA}, All1, 0, 0));
            cyc(1);
            e = sb.pop_front();
            n_vec++;
            if (((segments & e.msk) !== (e.seg & e.msk)) || (window_pos !== 3'(e.pos))
                || (wrap !== 1'(e.wrp))) begin
                n_err++;
                $display("FAIL static k=%0d: seg=%h pos=%0d wrap=%b, required seg=%h pos=%0d wrap=%0d",
                         k, segments, window_pos, wrap, e.seg, e.pos, e.wrp);
            end
        end
    endtask

    task automatic test_scroll();
        exp_t e;
        for (int i = 0; i < 8; i++) wr(3'(i), 6'(i));
        msg_len = 4'd5;
        cyc(1);
        mode = 2'b01;
        for (int k = 1; k <= 24; k++) begin
            // Digits 1 and 0 show codes 0 and 1 while the window sits at 3.
            if (k >= 14 && k <= 16) sb.push_back(mk({14'd0, G0, G1}, 28'h0003FFF, 3, 0));
            else sb.push_back(mk('0, '0, (k < 5) ? 0 : ((k - 1) / 4) % 5, (k == 21) ? 1 : 0));
            cyc(1);
            e = sb.pop_front();
            n_vec++;
            if (((segments & e.msk) !== (e.seg & e.msk)) || (window_pos !== 3'(e.pos))
                || (wrap !== 1'(e.wrp))) begin
                n_err++;
                $display("FAIL scroll k=%0d: seg=%h pos=%0d wrap=%b, required seg=%h mask=%h pos=%0d wrap=%0d",
                         k, segments, window_pos, wrap, e.seg, e.msk, e.pos, e.wrp);
            end
        end
    endtask

    task automatic test_blink();
        exp_t e;
        mode    = 2'b00;
        msg_len = 4'd4;
        wr(3'd0, 6'd17);
        wr(3'd1, 6'd0);
        wr(3'd2, 6'd0);
        wr(3'd3, 6'd0);
        cyc(2);
        mode = 2'b10;
        for (int k = 1; k <= 12; k++) begin
            if (k >= 5 && ((k - 5) / 3) % 2 == 0) sb.push_back(mk(All1, All1, 0, 0));
            else sb.push_back(mk({GH, G0, G0, G0}, All1, 0, 0));
            cyc(1);
            e = sb.pop_front();
            n_vec++;
            if ((segments !== e.seg) || (window_pos !== 3'(e.pos)) || (wrap !== 1'(e.wrp))) begin
                n_err++;
                $display("FAIL blink k=%0d: seg=%h pos=%0d wrap=%b, required seg=%h pos=%0d wrap=%0d",
                         k, segments, window_pos, wrap, e.seg, e.pos, e.wrp);
            end
        end
        // Leave blink while blanked; glyphs must be back within two cycles.
        mode = 2'b00;
        sb.push_back(mk('0, '0, 0, 0));
        sb.push_back(mk({GH, G0, G0, G0}, All1, 0, 0));
        sb.push_back(mk({GH, G0, G0, G0}, All1, 0, 0));
        for (int k = 1; k <= 3; k++) begin
            cyc(1);
            e = sb.pop_front();
            n_vec++;
            if (((segments & e.msk) !== (e.seg & e.msk)) || (window_pos !== 3'(e.pos))
                || (wrap !== 1'(e.wrp))) begin
                n_err++;
                $display("FAIL blink_exit k=%0d: seg=%h pos=%0d wrap=%b, required seg=%h pos=%0d wrap=%0d",
                         k, segments, window_pos, wrap, e.seg, e.pos, e.wrp);
            end
        end
    endtask

    task automatic test_shrink();
        exp_t e;
        // Buffer: 0=H 1..3=0 4..6=4..6 7=7
        msg_len = 4'd8;
        mode    = 2'b01;
        for (int k = 1; k <= 28; k++) begin
            if (k == 26) msg_len = 4'd3;
            sb.push_back(mk('0, '0, (k < 5) ? 0 : (k <= 25) ? ((k - 1) / 4) % 8 : 0, 0));
            cyc(1);
            e = sb.pop_front();
            n_vec++;
            if ((window_pos !== 3'(e.pos)) || (wrap !== 1'(e.wrp))) begin
                n_err++;
                $display("FAIL shrink k=%0d: pos=%0d wrap=%b, required pos=%0d wrap=%0d",
                         k, window_pos, wrap, e.pos, e.wrp);
            end
        end
        // Write beyond the active length: stored, not shown; short message repeats.
        mode = 2'b00;
        cyc(2);
        wr(3'd7, 6'd8);
        sb.push_back(mk({GH, G0, G0, GH}, All1, 0, 0));
        cyc(1);
        e = sb.pop_front();
        n_vec++;
        if ((segments !== e.seg) || (window_pos !== 3'(e.pos)) || (wrap !== 1'(e.wrp))) begin
            n_err++;
            $display("FAIL short_msg: seg=%h pos=%0d wrap=%b, required seg=%h pos=%0d wrap=%0d",
                     segments, window_pos, wrap, e.seg, e.pos, e.wrp);
        end
        // Scroll the full buffer to index 7 to see the stored write.
        msg_len = 4'd8;
        mode    = 2'b01;
        for (int k = 1; k <= 30; k++) begin
            if (k == 30) sb.push_back(mk({G8, GH, G0, G0}, All1, 7, 0));
            else sb.push_back(mk('0, '0, (k < 5) ? 0 : ((k - 1) / 4) % 8, 0));
            cyc(1);
            e = sb.pop_front();
            n_vec++;
            if (((segments & e.msk) !== (e.seg & e.msk)) || (window_pos !== 3'(e.pos))
                || (wrap !== 1'(e.wrp))) begin
                n_err++;
                $display("FAIL hidden_write k=%0d: seg=%h pos=%0d wrap=%b, required seg=%h pos=%0d wrap=%0d",
                         k, segments, window_pos, wrap, e.seg, e.pos, e.wrp);
            end
        end
    endtask

    task automatic test_collision();
        exp_t e;
        mode = 2'b00;
        cyc(2);
        mode = 2'b01;
        for (int k = 1; k <= 9; k++) begin
            // Write lands on the same edge as the first scroll tick.
            wr_en   = (k == 5);
            wr_addr = 3'd1;
            wr_data = 6'd1;
            if (k == 9) mode = 2'b11;
            if (k == 6) sb.push_back(mk({G1, G0, G0, 7'd0}, 28'hFFF_FF80, 1, 0));
            else sb.push_back(mk('0, '0, (k < 5) ? 0 : (k == 9) ? 0 : 1, 0));
            cyc(1);
            e = sb.pop_front();
            n_vec++;
            if (((segments & e.msk) !== (e.seg & e.msk)) || (window_pos !== 3'(e.pos))
                || (wrap !== 1'(e.wrp))) begin
                n_err++;
                $display("FAIL collision k=%0d: seg=%h pos=%0d wrap=%b, required seg=%h mask=%h pos=%0d wrap=%0d",
                         k, segments, window_pos, wrap, e.seg, e.msk, e.pos, e.wrp);
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        cyc(3);
        reset_n = 1'b0;
        #1;
        sb.push_back(mk(All1, All1, 0, 0));
        e = sb.pop_front();
        n_vec++;
        if ((segments !== e.seg) || (window_pos !== 3'(e.pos)) || (wrap !== 1'(e.wrp))) begin
            n_err++;
            $display("FAIL reset_mid: seg=%h pos=%0d wrap=%b, required seg=%h pos=%0d wrap=%0d",
                     segments, window_pos, wrap, e.seg, e.pos, e.wrp);
        end
        mode    = 2'b00;
        msg_len = 4'd4;
        cyc(2);
        reset_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            sb.push_back(mk(All1, All1, 0, 0));
            cyc(1);
            e = sb.pop_front();
            n_vec++;
            if ((segments !== e.seg) || (window_pos !== 3'(e.pos)) || (wrap !== 1'(e.wrp))) begin
                n_err++;
                $display("FAIL reset_mid_release k=%0d: seg=%h pos=%0d wrap=%b, required seg=%h pos=%0d wrap=%0d",
                         k, segments, window_pos, wrap, e.seg, e.pos, e.wrp);
            end
        end
    endtask

    initial begin
        reset_n = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        msg_len = 4'd4;
        mode    = 2'b00;
        test_reset();
        test_static();
        test_scroll();
        test_blink();
        test_shrink();
        test_collision();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seven_seg_scroller.md
Name: seven_seg_scroller

Overview:
- Parametrised multi-digit seven-segment display engine for the board HEX displays.
- Holds a character message buffer and decodes a sliding window of DIGITS characters to active-low segment patterns.
- Modes: static, timed scrolling, blinking, or scroll+blink.
- Sits between game control logic (score, card and status messages) and the top-level pin wrapper.

Parameters:
- DIGITS, 4, number of displayed digits (1..8).
- DEPTH, 16, message buffer entries (2..64, power of two not required).
- TICKS, 12_500_000, clk cycles per scroll step (>=1).
- BLINK_TICKS, 6_250_000, clk cycles per blink half-period (>=1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- wr_en  in  1  buffer write strobe.
- wr_addr  in  $clog2(DEPTH)  buffer write index.
- wr_data  in  6  character code.
- msg_len  in  $clog2(DEPTH)+1  active message length.
- mode  in  2  00 static, 01 scroll, 10 blink, 11 scroll+blink.
- segments  out  7*DIGITS  digit d at [7*d+6:7*d], bit order abc_defg (bit6=a), active-low; digit DIGITS-1 is leftmost.
- window_pos  out  $clog2(DEPTH)  buffer index shown on the leftmost digit.
- wrap  out  1  one-cycle pulse when window_pos returns to 0 by scrolling.

Behaviour:
- Reset (async assert, sync release): buffer all entries = 63 (blank); segments = all ones; window_pos = 0; tick and blink counters = 0; blink phase = on; wrap = 0; mode_q = 00.
- Character codes:
  - 0-9 are digits; 10-35 are letters A-Z using the team glyph set.
  - 36-63 are blank (7'b111_1111).
  - Required glyphs: 0=000_0001, 1=100_1111, 8=000_0000, A=000_1000, H=110_1000.
- Writes: if wr_en and wr_addr<DEPTH, buffer[wr_addr] <= wr_data at the clock edge. Writes with wr_addr>=DEPTH are ignored.
- Effective length: len_eff = DEPTH if msg_len==0 or msg_len>DEPTH, else msg_len.
- Window mapping: leftmost digit (d=DIGITS-1) shows buffer[window_pos]; digit d shows buffer[(window_pos + DIGITS-1-d) mod len_eff].
- Output registering: segments is registered. Any change to the buffer, window_pos, mode or blink phase appears on segments exactly 1 cycle after it takes effect. A write therefore shows on the cycle after the following edge.
- Mode change: mode is registered into mode_q each cycle. When mode != mode_q, tick counter, blink counter and window_pos are cleared to 0 and blink phase is set to on in that same cycle.
- Scroll (mode_q[0]=1):
  - Tick counter counts 0..TICKS-1 and wraps.
  - At terminal count, window_pos <= (window_pos+1 == len_eff) ? 0 : window_pos+1.
  - wrap pulses high for the cycle in which window_pos becomes 0 by this rule.
  - With TICKS=1 the window advances every cycle.
- Static (mode_q[0]=0): window_pos held at 0, tick counter held at 0, wrap = 0.
- Blink (mode_q[1]=1):
  - Blink counter counts 0..BLINK_TICKS-1; phase toggles at terminal count.
  - Phase off forces all segments = 1 (blank). Scrolling continues underneath.
- No blink (mode_q[1]=0): phase held on, blink counter held at 0.
- msg_len shrink: if window_pos >= len_eff (e.g. msg_len reduced), window_pos <= 0 next cycle. This takes priority over a tick; no wrap pulse is generated.
- Simultaneous events:
  - A write and a scroll tick in the same cycle both take effect.
  - A mode change overrides the tick and blink toggle in the same cycle.
- Reset mid-scroll: everything returns to reset values immediately, including the buffer; the buffer must be rewritten afterwards.
- Length smaller than digit count (len_eff < DIGITS): the window repeats the message modulo len_eff.

Test Plan:
All scenarios use DIGITS=4, DEPTH=8, TICKS=4, BLINK_TICKS=3.
1. Reset: assert reset_n=0 mid-operation -> segments=28'hFFFFFFF immediately, window_pos=0, wrap=0; after release with mode=00 segments stay all-blank.
2. Static load: write codes 1,0,8,10 to addr 0..3, msg_len=4, mode=00 -> two cycles after last write, segments = {100_1111, 000_0001, 000_0000, 000_1000} (leftmost first).
3. Scroll/wrap:
   - Stimulus: buffer 0..7 = 0..7, msg_len=5, mode=01.
   - window_pos steps 0→1→2→3→4→0, one step every 4 cycles.
   - wrap high for exactly 1 cycle at 4→0.
   - At window_pos=3 the leftmost-to-rightmost digits show codes 3,4,0,1.
4. Blink: static message "H000" with mode=10 -> segments alternate glyphs / all-ones every 3 cycles. Switching to mode=00 restores glyphs within 2 cycles with window_pos=0.
5. Shrink and out-of-range: at window_pos=6 with msg_len=8, set msg_len=3 -> next cycle window_pos=0 with no wrap pulse. A write with wr_addr=7 while msg_len=3 is stored but not shown.
6. Collision: write to addr window_pos+1 on the same cycle as a scroll tick -> both the new window and the new data are visible on segments 2 cycles later; mode change on a tick cycle -> window_pos=0.
